serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal 2..16).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; samples A, B when accepted.
REQ-005 SHALL have port A  input  WIDTH  minuend, unsigned.
REQ-006 SHALL have port B  input  WIDTH  subtrahend, unsigned.
REQ-007 SHALL have port busy  output  1  high while a subtraction is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse; diff/borrow valid.
REQ-009 SHALL have port diff  output  WIDTH  registered result (A-B) mod 2^WIDTH.
REQ-010 SHALL have port borrow  output  1  registered final borrow (1 when A<B).

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-012 IDLE: start=1 SHALL load A and B into internal shift registers, clear borrow state, set bit counter to WIDTH, go to SHIFT.
REQ-013 SHIFT: each cycle SHALL process LSB-first: d = a0^b0^bw; next bw = (~a0&b0) | (~(a0^b0)&bw).
REQ-014 SHIFT: operand registers SHALL shift right one bit; d SHALL enter the MSB of an internal result shift register; counter SHALL decrement.
REQ-015 SHIFT SHALL last exactly WIDTH cycles, then go to DONE.
REQ-016 DONE: diff SHALL load the result shift register, borrow SHALL load final bw, done=1 for that cycle only, next state IDLE.
REQ-017 Latency: start sampled at edge k SHALL give done=1 in the cycle after edge k+WIDTH+1; throughput one operation per WIDTH+2 cycles.
REQ-018 busy SHALL be 1 in SHIFT and DONE, 0 in IDLE.
REQ-019 start while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-020 diff and borrow SHALL hold their value until the next DONE; changes to A or B after acceptance SHALL NOT affect the result.
REQ-021 Intermediate result bits SHALL NOT be visible on diff.

Reset
REQ-022 reset=1 SHALL force state IDLE, counter 0, borrow state 0, diff 0, borrow 0, done 0, busy 0.
REQ-023 reset during SHIFT or DONE SHALL abort the operation; no done pulse SHALL follow; diff SHALL read 0.
REQ-024 reset and start asserted together SHALL give reset priority; the start is dropped.

Configuration
REQ-025 Macro SERIAL_SUBTRACTOR_OVERFLOW_EN defined: the block SHALL add port overflow  output  1, holding the two's-complement signed overflow of A-B.
REQ-026 overflow SHALL equal (a_msb != b_msb) && (d_msb != a_msb), be registered at DONE, and be reset to 0 like borrow.
REQ-027 Macro undefined: the overflow port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-028 reset, A=100, B=37, start pulse -> done after 10 cycles (WIDTH=8), diff=63, borrow=0; overflow=0 with macro.
REQ-029 A=37, B=100 -> diff=193 (0xC1), borrow=1; A=0, B=1 -> diff=255, borrow=1; A=255, B=255 -> diff=0, borrow=0.
REQ-030 start held high for 20 cycles with A=9, B=4 -> done pulses at cycles 10 and 20; each pulse lasts exactly 1 cycle; diff=5.
REQ-031 accept A=50, B=20, then change A/B and pulse start during SHIFT -> diff=30 and only one done pulse.
REQ-032 reset asserted at the 4th SHIFT cycle -> busy=0 next cycle, no done pulse, diff=0; a new operation 200-55 then yields diff=145.
REQ-033 with macro: A=0x80, B=0x01 -> diff=0x7F, overflow=1, borrow=0; A=0x7F, B=0xFF -> diff=0x80, overflow=1, borrow=1.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, LSB first, one bit per cycle.
//   clock  : sole clock, rising edge
//   reset  : synchronous, active-high; aborts any operation in progress
//   start  : request; A/B are captured when accepted in IDLE
//   A, B   : minuend / subtrahend (unsigned, WIDTH bits)
//   busy   : high while the FSM is in SHIFT or DONE
//   done   : one-cycle pulse; diff/borrow (and overflow) valid
//   diff   : registered (A-B) mod 2^WIDTH, held until the next completion
//   borrow : registered final borrow (1 when A<B)
// Optional feature: define SERIAL_SUBTRACTOR_OVERFLOW_EN to add the output
//   overflow : registered two's-complement signed overflow of A-B.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bw_q, bw_d, borrow_q, borrow_d, done_q, done_d;
  logic             d_bit;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  // Operand sign bits are shifted out during SHIFT, so keep copies.
  logic             amsb_q, amsb_d, bmsb_q, bmsb_d, ovf_q, ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    bw_d     = bw_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    done_d   = 1'b0;
    d_bit    = 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    amsb_d   = amsb_q;
    bmsb_d   = bmsb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          res_d   = '0;
          bw_d    = 1'b0;
          cnt_d   = CW'(WIDTH);
          state_d = SHIFT;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
          amsb_d  = A[WIDTH-1];
          bmsb_d  = B[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        d_bit = a_q[0] ^ b_q[0] ^ bw_q;
        bw_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bw_q);
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        // Result fills from the top so bit 0 lands in place after WIDTH shifts.
        res_d = {d_bit, res_q[WIDTH-1:1]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        // Only here does the result become visible; partial bits never reach diff.
        diff_d   = res_q;
        borrow_d = bw_q;
        done_d   = 1'b1;
        state_d  = IDLE;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        ovf_d    = (amsb_q != bmsb_q) && (res_q[WIDTH-1] != amsb_q);
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bw_q     <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      amsb_q   <= 1'b0;
      bmsb_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      bw_q     <= bw_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      done_q   <= done_d;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      amsb_q   <= amsb_d;
      bmsb_q   <= bmsb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): stimulus pushes expected
// results, a negedge monitor pops and compares on every done pulse.
module tb_serial_subtractor;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] d;
    logic         b;
    logic         o;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset, start;
  logic [W-1:0] A, B, diff;
  logic         busy, done, borrow;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic         overflow;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    , .overflow(overflow)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("diff", 32'(diff), 32'(e.d));
        chk("borrow", 32'(borrow), 32'(e.b));
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        chk("overflow", 32'(overflow), 32'(e.o));
`endif
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // Single accepted operation; checks latency start->done.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [W-1:0] ed, input logic eb, input logic eo);
    int n;
    exp_t e;
    e.d = ed; e.b = eb; e.o = eo;
    @(negedge clock);
    A = a; B = b; start = 1'b1;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("latency", 32'(n), 32'(W + 1));
  endtask

  // Counts done pulses over a window of cycles.
  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (done === 1'b1) cnt++;
    end
  endtask

  initial begin
    int pos[$];
    int c;
    exp_t e;
    reset = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    reset = 1'b0;

    // Directed vectors
    op(8'd100, 8'd37,  8'd63,  1'b0, 1'b0);
    op(8'd37,  8'd100, 8'd193, 1'b1, 1'b0);
    op(8'd0,   8'd1,   8'd255, 1'b1, 1'b0);
    op(8'd255, 8'd255, 8'd0,   1'b0, 1'b0);
    op(8'h80,  8'h01,  8'h7F,  1'b0, 1'b1);
    op(8'h7F,  8'hFF,  8'h80,  1'b1, 1'b1);
    // Result holds after done
    repeat (3) @(negedge clock);
    chk("diff_hold", 32'(diff), 32'h80);

    // start held high: back-to-back ops, each done a single cycle
    e.d = 8'd5; e.b = 1'b0; e.o = 1'b0;
    sb.push_back(e); sb.push_back(e);
    A = 8'd9; B = 8'd4; start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (done === 1'b1) pos.push_back(i);
    end
    start = 1'b0;
    chk("held_pulses", 32'(pos.size()), 32'd2);
    if (pos.size() == 2) begin
      chk("held_pos0", 32'(pos[0]), 32'd9);
      chk("held_pos1", 32'(pos[1]), 32'd19);
    end
    count_done(12, c);
    chk("held_no_extra", 32'(c), 32'd0);

    // Operand change and start during SHIFT are ignored
    e.d = 8'd30; e.b = 1'b0; e.o = 1'b0;
    @(negedge clock);
    A = 8'd50; B = 8'd20; start = 1'b1;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    A = 8'd1; B = 8'd2; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    count_done(W + 12, c);
    chk("ignored_start_pulses", 32'(c), 32'd1);

    // Reset in the 4th SHIFT cycle aborts
    @(negedge clock);
    A = 8'd77; B = 8'd11; start = 1'b1;
    @(negedge clock);             // 1st SHIFT cycle
    start = 1'b0;
    repeat (3) @(negedge clock);  // 4th SHIFT cycle
    chk("busy_before_abort", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    reset = 1'b0;
    count_done(W + 4, c);
    chk("abort_no_done", 32'(c), 32'd0);
    op(8'd200, 8'd55, 8'd145, 1'b0, 1'b0);

    // reset and start together: reset wins
    @(negedge clock);
    reset = 1'b1; start = 1'b1; A = 8'd3; B = 8'd1;
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    chk("rst_start_busy", 32'(busy), 32'd0);
    count_done(W + 4, c);
    chk("rst_start_no_done", 32'(c), 32'd0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
